dmem_arbiter: RTL and testbench

- Arbitrates the single-port data memory between the single-cycle CPU load/store path and a host/debug port used for data preload and readback.
- Sits between the CPU datapath and the data memory. The memory is synchronous: write on the clock edge, read data valid one cycle after the address is issued.
- Stalls the CPU (holds the PC and register write) whenever the CPU's access cannot complete in the current cycle.
- A starvation counter guarantees host progress under continuous CPU traffic.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/arb_wait_counter.sv | 26 ++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter: FSM states and
// grant encoding used by the top-level mux.
package dmem_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CPU_RSP     = 2'd1,
    HOST_RSP    = 2'd2,
    HOST_WR_ACK = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_HOST = 2'd2
  } gnt_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating starvation counter: counts consecutive refusals of a pending
// host request and flags when the host must be granted.
module arb_wait_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] cnt,
  output logic       at_max
);

  assign at_max = (cnt == 4'(MAX_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU load/store path and the
// host/debug port, with a starvation bound on host requests.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state, state_nxt;
  gnt_t              gnt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cpu_word;
  logic              wc_inc, wc_clr, wc_at_max;
  logic [3:0]        wc_cnt;
  logic              unused_addr_bits;

  // Byte address to word address; upper bits alias, low two bits are ignored.
  assign cpu_word         = cpu_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0], wc_cnt};

  arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk    (clk),
    .rst    (rst),
    .inc    (wc_inc),
    .clr    (wc_clr),
    .cnt    (wc_cnt),
    .at_max (wc_at_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= mem_addr;
    end
  end

  // mem_addr falls back to addr_q so the address holds outside grant cycles.
  always_comb begin
    state_nxt  = state;
    gnt        = GNT_NONE;
    wc_inc     = 1'b0;
    wc_clr     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = addr_q;
    mem_wdata  = '0;
    cpu_stall  = 1'b0;
    cpu_rvalid = 1'b0;
    cpu_rdata  = '0;
    host_ack   = 1'b0;
    host_rdata = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (host_req && (wc_at_max || !cpu_req)) begin
            gnt = GNT_HOST;
          end else if (cpu_req) begin
            gnt = GNT_CPU;
          end
          wc_inc = host_req && (gnt != GNT_HOST);
          wc_clr = (gnt == GNT_HOST);
          case (gnt)
            GNT_CPU: begin
              mem_addr = cpu_word;
              if (cpu_we) begin
                mem_we    = 1'b1;
                mem_wdata = cpu_wdata;
              end else begin
                cpu_stall = 1'b1;
                state_nxt = CPU_RSP;
              end
            end
            GNT_HOST: begin
              mem_addr  = host_addr;
              cpu_stall = cpu_req;
              if (host_we) begin
                mem_we    = 1'b1;
                mem_wdata = host_wdata;
                state_nxt = HOST_WR_ACK;
              end else begin
                state_nxt = HOST_RSP;
              end
            end
            default: ;
          endcase
        end
        CPU_RSP: begin
          cpu_rvalid = 1'b1;
          cpu_rdata  = mem_rdata;
          state_nxt  = IDLE;
        end
        HOST_RSP: begin
          host_ack   = 1'b1;
          host_rdata = mem_rdata;
          cpu_stall  = cpu_req;
          state_nxt  = IDLE;
        end
        HOST_WR_ACK: begin
          host_ack  = 1'b1;
          cpu_stall = cpu_req;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset-abort sequence and
// randomized traffic against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [31:0]   cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_rvalid, cpu_stall;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          host_ack;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] mem [32] = '{default: '0};

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory: write on the edge, read data next cycle.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic        creq, cwe;
    logic [31:0] caddr, cwdata;
    logic        hreq, hwe;
    logic [4:0]  haddr;
    logic [31:0] hwdata;
    logic        stall, mwe;
    logic [4:0]  maddr;
    logic        ack, rv;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [22];
  vec_t none;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: which response is owed next cycle, refusal count, shadow memory.
  int          pend;          // 0 none, 1 cpu read data, 2 host read data, 3 host write ack
  int          refused;
  logic [4:0]  last;
  logic [31:0] ref_mem [32];
  logic        m_cpu_go, m_host_go;
  logic        e_stall, e_we, e_rv, e_ack;
  logic [4:0]  e_addr;
  logic [31:0] e_wdata, e_crd, e_hrd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    {e_stall, e_we, e_rv, e_ack} = '0;
    e_wdata = '0; e_crd = '0; e_hrd = '0;
    e_addr = last;
    m_cpu_go = 1'b0; m_host_go = 1'b0;
    if (rst) begin
      e_addr = '0;
    end else if (pend == 0) begin
      m_host_go = host_req && (refused == MW || !cpu_req);
      m_cpu_go  = cpu_req && !m_host_go;
      if (m_host_go) begin
        e_addr  = host_addr;
        e_stall = cpu_req;
        e_we    = host_we;
        e_wdata = host_we ? host_wdata : '0;
      end else if (m_cpu_go) begin
        e_addr  = cpu_addr[AW+1:2];
        e_stall = !cpu_we;
        e_we    = cpu_we;
        e_wdata = cpu_we ? cpu_wdata : '0;
      end
    end else if (pend == 1) begin
      e_rv  = 1'b1;
      e_crd = ref_mem[last];
    end else begin
      e_ack   = 1'b1;
      e_stall = cpu_req;
      if (pend == 2) e_hrd = ref_mem[last];
    end
  endtask

  task automatic model_update();
    if (rst) begin
      pend = 0; refused = 0; last = '0;
    end else if (pend != 0) begin
      pend = 0;
    end else if (m_host_go) begin
      last = host_addr;
      refused = 0;
      if (host_we) begin
        ref_mem[host_addr] = host_wdata;
        pend = 3;
      end else begin
        pend = 2;
      end
    end else begin
      if (host_req && refused < MW) refused++;
      if (m_cpu_go) begin
        last = cpu_addr[AW+1:2];
        if (cpu_we) ref_mem[last] = cpu_wdata;
        else pend = 1;
      end
    end
  endtask

  task automatic step(input bit has_row, input vec_t v, input int idx);
    @(negedge clk);
    model_eval();
    chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, e_stall});
    chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, e_rv});
    chk("cpu_rdata", cpu_rdata, e_crd);
    chk("host_ack", {31'd0, host_ack}, {31'd0, e_ack});
    chk("host_rdata", host_rdata, e_hrd);
    chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
    chk("mem_addr", {27'd0, mem_addr}, {27'd0, e_addr});
    chk("mem_wdata", mem_wdata, e_wdata);
    if (has_row) begin
      chk($sformatf("row%0d_stall", idx), {31'd0, cpu_stall}, {31'd0, v.stall});
      chk($sformatf("row%0d_mem_we", idx), {31'd0, mem_we}, {31'd0, v.mwe});
      chk($sformatf("row%0d_mem_addr", idx), {27'd0, mem_addr}, {27'd0, v.maddr});
      chk($sformatf("row%0d_ack", idx), {31'd0, host_ack}, {31'd0, v.ack});
      chk($sformatf("row%0d_rvalid", idx), {31'd0, cpu_rvalid}, {31'd0, v.rv});
      if (v.rv) chk($sformatf("row%0d_cpu_rdata", idx), cpu_rdata, v.rdata);
      if (v.ack) chk($sformatf("row%0d_host_rdata", idx), host_rdata, v.rdata);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic apply(input vec_t v);
    cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwdata;
    host_req = v.hreq; host_we = v.hwe; host_addr = v.haddr; host_wdata = v.hwdata;
  endtask

  initial begin
    pend = 0; refused = 0; last = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    none = '{0,0,32'h0,32'h0, 0,0,5'd0,32'h0, 0,0,5'd0,0,0,32'h0};

    //            creq cwe caddr    cwdata        hreq hwe haddr hwdata        stall mwe maddr ack rv rdata
    tbl[0]  = '{1,1,32'h0C,32'hDEADBEEF, 0,0,5'd0,32'h0,        0,1,5'd3,0,0,32'h0};
    tbl[1]  = '{1,0,32'h0C,32'h0,        0,0,5'd0,32'h0,        1,0,5'd3,0,0,32'h0};
    tbl[2]  = '{1,0,32'h0C,32'h0,        0,0,5'd0,32'h0,        0,0,5'd3,0,1,32'hDEADBEEF};
    tbl[3]  = '{0,0,32'h0,32'h0,         1,1,5'd7,32'h12345678, 0,1,5'd7,0,0,32'h0};
    tbl[4]  = '{0,0,32'h0,32'h0,         1,1,5'd7,32'h12345678, 0,0,5'd7,1,0,32'h0};
    tbl[5]  = '{0,0,32'h0,32'h0,         1,0,5'd7,32'h0,        0,0,5'd7,0,0,32'h0};
    tbl[6]  = '{0,0,32'h0,32'h0,         1,0,5'd7,32'h0,        0,0,5'd7,1,0,32'h12345678};
    tbl[7]  = '{0,0,32'h0,32'h0,         0,0,5'd0,32'h0,        0,0,5'd7,0,0,32'h0};
    for (int i = 8; i < 12; i++)
      tbl[i] = '{1,1,32'h10,32'h100 + 32'(i), 1,1,5'd9,32'hA5A5A5A5, 0,1,5'd4,0,0,32'h0};
    tbl[12] = '{1,1,32'h10,32'h104,      1,1,5'd9,32'hA5A5A5A5, 1,1,5'd9,0,0,32'h0};
    tbl[13] = '{1,1,32'h10,32'h104,      1,1,5'd9,32'hA5A5A5A5, 1,0,5'd9,1,0,32'h0};
    tbl[14] = '{1,1,32'h10,32'h105,      0,0,5'd0,32'h0,        0,1,5'd4,0,0,32'h0};
    tbl[15] = '{1,0,32'h24,32'h0,        1,1,5'd2,32'h0BADF00D, 1,0,5'd9,0,0,32'h0};
    tbl[16] = '{1,0,32'h24,32'h0,        1,1,5'd2,32'h0BADF00D, 0,0,5'd9,0,1,32'hA5A5A5A5};
    tbl[17] = '{0,0,32'h0,32'h0,         1,1,5'd2,32'h0BADF00D, 0,1,5'd2,0,0,32'h0};
    tbl[18] = '{0,0,32'h0,32'h0,         1,1,5'd2,32'h0BADF00D, 0,0,5'd2,1,0,32'h0};
    tbl[19] = '{1,1,32'h8B,32'h55,       0,0,5'd0,32'h0,        0,1,5'd2,0,0,32'h0};
    tbl[20] = '{1,0,32'h0A,32'h0,        0,0,5'd0,32'h0,        1,0,5'd2,0,0,32'h0};
    tbl[21] = '{1,0,32'h0A,32'h0,        0,0,5'd0,32'h0,        0,0,5'd2,0,1,32'h55};

    // Reset with active requests: every output must stay low.
    rst = 1'b1;
    apply('{1,0,32'h1C,32'h1, 1,1,5'd3,32'hFFFF, 0,0,5'd0,0,0,32'h0});
    @(posedge clk); #1;
    step(0, none, 0);
    step(0, none, 0);
    rst = 1'b0;
    apply(none);
    step(0, none, 0);

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i]);
      step(1, tbl[i], i);
    end

    // Reset while a host read is waiting for its data: the ack is dropped.
    apply('{0,0,32'h0,32'h0, 1,0,5'd7,32'h0, 0,0,5'd0,0,0,32'h0});
    step(0, none, 0);
    rst = 1'b1;
    step(0, none, 0);
    chk("rst_abort_ack", {31'd0, host_ack}, 32'd0);
    host_req = 1'b0;
    step(0, none, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(0, none, 0);
    apply('{1,1,32'h14,32'hCAFEF00D, 0,0,5'd0,32'h0, 0,0,5'd0,0,0,32'h0});
    step(0, none, 0);
    chk("post_rst_store_addr", {27'd0, mem_addr}, 32'd5);
    apply('{1,0,32'h14,32'h0, 0,0,5'd0,32'h0, 0,0,5'd0,0,0,32'h0});
    step(0, none, 0);
    step(0, none, 0);

    // Randomized traffic: stalled CPU holds its request, host holds until ack.
    apply(none);
    for (int c = 0; c < 1500; c++) begin
      if (host_req && e_ack) host_req = 1'b0;
      else if (!host_req && $urandom_range(0, 3) == 0) begin
        host_req   = 1'b1;
        host_we    = $urandom_range(0, 1) == 1;
        host_addr  = 5'($urandom_range(0, 31));
        host_wdata = $urandom;
      end
      if (!e_stall) begin
        cpu_req   = $urandom_range(0, 3) != 0;
        cpu_we    = $urandom_range(0, 1) == 1;
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
      end
      rst = ($urandom_range(0, 199) == 0);
      if (rst) host_req = 1'b0;
      step(0, none, 0);
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
